// File: rtl/wb_regfile.sv
// Write-back stage: selects and extends the W-stage result, commits it to the GPR file,
// serves the two D-stage read ports with same-cycle W->D bypass, and counts committed writes.
module wb_regfile #(
  parameter int DW    = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteW,
  input  logic [1:0]       MemtoRegW,
  input  logic [DW-1:0]    ReadDataW,
  input  logic [DW-1:0]    ALUOutW,
  input  logic [4:0]       WriteRegW,
  input  logic [DW-1:0]    PC8W,
  input  logic [2:0]       LdTypeW,
  input  logic [4:0]       A1D,
  input  logic [4:0]       A2D,
  output logic [DW-1:0]    RD1D,
  output logic [DW-1:0]    RD2D,
  output logic [DW-1:0]    WDW,
  output logic             WeW,
  output logic [CNT_W-1:0] wb_count
);

  logic [DW-1:0]    gpr_r [NREG];
  logic [CNT_W-1:0] wb_count_r;
  logic [DW-1:0]    ld_ext_s;

  // Byte offset picks the lane; halfword selection uses only offset bit 1.
  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] raw,
                                                input logic [1:0]    off,
                                                input logic [2:0]    ld);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [DW-1:0] res_v;
    byte_v = raw[{off, 3'b000} +: 8];
    half_v = raw[{off[1], 4'b0000} +: 16];
    case (ld)
      3'b001:  res_v = {{(DW-8){byte_v[7]}}, byte_v};
      3'b010:  res_v = {{(DW-8){1'b0}}, byte_v};
      3'b011:  res_v = {{(DW-16){half_v[15]}}, half_v};
      3'b100:  res_v = {{(DW-16){1'b0}}, half_v};
      default: res_v = raw;
    endcase
    return res_v;
  endfunction

  // Write-back value selection and effective write enable.
  always_comb begin
    ld_ext_s = load_extend(ReadDataW, ALUOutW[1:0], LdTypeW);
    case (MemtoRegW)
      2'b00:   WDW = ALUOutW;
      2'b01:   WDW = ld_ext_s;
      2'b10:   WDW = PC8W;
      default: WDW = {DW{1'b0}};
    endcase
    if (RegWriteW && (WriteRegW != 5'd0) && (MemtoRegW != 2'b11)) begin
      WeW = 1'b1;
    end else begin
      WeW = 1'b0;
    end
  end

  // Read port 1: $0 reads zero, a matching in-flight write is bypassed.
  always_comb begin
    if (A1D == 5'd0) begin
      RD1D = {DW{1'b0}};
    end else if (WeW && (A1D == WriteRegW)) begin
      RD1D = WDW;
    end else begin
      RD1D = gpr_r[A1D];
    end
  end

  // Read port 2: same rule as port 1, evaluated independently.
  always_comb begin
    if (A2D == 5'd0) begin
      RD2D = {DW{1'b0}};
    end else if (WeW && (A2D == WriteRegW)) begin
      RD2D = WDW;
    end else begin
      RD2D = gpr_r[A2D];
    end
  end

  // GPR storage; reset wins over a write pending on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_r[i] <= {DW{1'b0}};
      end
    end else if (WeW) begin
      gpr_r[WriteRegW] <= WDW;
    end else begin
      gpr_r[WriteRegW] <= gpr_r[WriteRegW];
    end
  end

  // Committed-write counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_count_r <= {CNT_W{1'b0}};
    end else if (WeW) begin
      wb_count_r <= wb_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wb_count_r <= wb_count_r;
    end
  end

  assign wb_count = wb_count_r;

endmodule
